mem_read_arbiter: RTL and testbench

- Shares the single data-side memory read port (AXI-style AR/R channels, 64-bit data) between two requesters: m0 = IFU instruction fetch, m1 = LSU loads from the EXU.
- Sits between the core and the interconnect.
- Grants one read transaction at a time and routes R beats back to the owner.
- Recovers from an unresponsive slave with a watchdog timeout.
- Write channels do not pass through this block.

---
 rtl/mem_read_arbiter.sv | 176 +++++++++++++++++
 tb/tb_mem_read_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_read_arbiter.sv
// Read-port arbiter: IFU (m0) and LSU (m1) share one AXI-style AR/R port, one transaction at a time, with an R watchdog.
// ARB_ROUND_ROBIN_EN: ties go to the master not granted most recently; otherwise m1 always wins a tie.
module mem_read_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int TIMEOUT    = 1023
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    m0_arvalid,
  output logic                    m0_arready,
  input  logic [ADDR_WIDTH+16:0]  m0_ar_info,
  output logic                    m0_rvalid,
  input  logic                    m0_rready,
  output logic [DATA_WIDTH+6:0]   m0_r_info,
  input  logic                    m1_arvalid,
  output logic                    m1_arready,
  input  logic [ADDR_WIDTH+16:0]  m1_ar_info,
  output logic                    m1_rvalid,
  input  logic                    m1_rready,
  output logic [DATA_WIDTH+6:0]   m1_r_info,
  output logic                    s_arvalid,
  input  logic                    s_arready,
  output logic [ADDR_WIDTH+16:0]  s_ar_info,
  input  logic                    s_rvalid,
  output logic                    s_rready,
  input  logic [DATA_WIDTH+6:0]   s_r_info,
  output logic [1:0]              grant,
  output logic                    timeout_pulse
);

  localparam int AIW = ADDR_WIDTH + 17;
  localparam int RIW = DATA_WIDTH + 7;
  localparam int CW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_VAL  = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam bit WD_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {IDLE, AR_SEND, R_WAIT, DRAIN} state_t;

  state_t         state_q, state_d;
  logic [AIW-1:0] ar_q, ar_d;
  logic           owner_q, owner_d;   // 1 = m1 owns the port
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           tpulse_q, tpulse_d;
  logic           win_m1;

  logic           own_arready;
  logic           own_rvalid;
  logic           own_rready;
  logic [RIW-1:0] own_r_info;

  logic [3:0]     lat_id;
  logic           id_match;
  logic           to_hit;
  logic [RIW-1:0] synth_beat;

  assign lat_id     = ar_q[16:13];
  assign id_match   = (s_r_info[3:0] == lat_id);
  assign to_hit     = WD_EN && (cnt_q == TO_VAL);
  assign synth_beat = {{DATA_WIDTH{1'b0}}, 2'b10, 1'b1, lat_id};
  assign own_rready = owner_q ? m1_rready : m0_rready;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_q, last_d;   // 1 = m1 was granted most recently

  always_comb begin
    win_m1 = m1_arvalid && (!m0_arvalid || !last_q);
    last_d = last_q;
    if (state_q == IDLE && (m0_arvalid || m1_arvalid)) last_d = win_m1;
  end

  always_ff @(posedge clock) begin
    if (reset) last_q <= 1'b1;
    else       last_q <= last_d;
  end
`else
  always_comb win_m1 = m1_arvalid;
`endif

  always_comb begin
    state_d     = state_q;
    ar_d        = ar_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    tpulse_d    = 1'b0;
    s_arvalid   = 1'b0;
    s_rready    = 1'b0;
    own_arready = 1'b0;
    own_rvalid  = 1'b0;
    own_r_info  = '0;
    case (state_q)
      IDLE: begin
        if (m0_arvalid || m1_arvalid) begin
          owner_d = win_m1;
          ar_d    = win_m1 ? m1_ar_info : m0_ar_info;
          state_d = AR_SEND;
        end
      end
      AR_SEND: begin
        s_arvalid   = 1'b1;
        own_arready = s_arready;
        if (s_arready) begin
          state_d = R_WAIT;
          cnt_d   = '0;
        end
      end
      R_WAIT: begin
        // Once the watchdog fires, the synthesized error beat is held and the slave is left stalled.
        if (to_hit) begin
          own_rvalid = 1'b1;
          own_r_info = synth_beat;
          if (own_rready) begin
            tpulse_d = 1'b1;
            state_d  = DRAIN;
            cnt_d    = '0;
          end
        end else if (s_rvalid && id_match) begin
          own_rvalid = 1'b1;
          own_r_info = s_r_info;
          s_rready   = own_rready;
          if (own_rready) begin
            cnt_d = '0;
            if (s_r_info[4]) state_d = IDLE;
          end
        end else begin
          // Stray-id beats are swallowed and still count as waiting.
          s_rready = s_rvalid;
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        s_rready = 1'b1;
        if (s_rvalid && s_r_info[4]) begin
          state_d = IDLE;
        end else if (cnt_q == TO_VAL) begin
          state_d = IDLE;
        end else if (!s_rvalid && cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m0_arready = own_arready & ~owner_q;
    m1_arready = own_arready & owner_q;
    m0_rvalid  = own_rvalid & ~owner_q;
    m1_rvalid  = own_rvalid & owner_q;
    m0_r_info  = owner_q ? '0 : own_r_info;
    m1_r_info  = owner_q ? own_r_info : '0;
    grant      = 2'b00;
    if (state_q == AR_SEND || state_q == R_WAIT) grant = owner_q ? 2'b10 : 2'b01;
  end

  assign s_ar_info     = ar_q;
  assign timeout_pulse = tpulse_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      ar_q     <= '0;
      owner_q  <= 1'b0;
      cnt_q    <= '0;
      tpulse_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ar_q     <= ar_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      tpulse_q <= tpulse_d;
    end
  end

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Bench for mem_read_arbiter: cycle-exact hand sequences, an arbitration table, and a randomized
// two-master run checked against a transaction-level model of who should win and what each master receives.
module tb_mem_read_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 64;
  localparam int TO  = 8;
  localparam int AIW = AW + 17;
  localparam int RIW = DW + 7;

  logic           clock = 1'b0;
  logic           reset;
  logic [1:0]     m_arvalid, m_arready, m_rvalid, m_rready;
  logic [AIW-1:0] m_ar_info [2];
  logic [RIW-1:0] m_r_info [2];
  logic           s_arvalid, s_arready, s_rvalid, s_rready;
  logic [AIW-1:0] s_ar_info;
  logic [RIW-1:0] s_r_info;
  logic [1:0]     grant;
  logic           timeout_pulse;

  always #5 clock = ~clock;

  mem_read_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .m0_arvalid(m_arvalid[0]), .m0_arready(m_arready[0]), .m0_ar_info(m_ar_info[0]),
    .m0_rvalid(m_rvalid[0]), .m0_rready(m_rready[0]), .m0_r_info(m_r_info[0]),
    .m1_arvalid(m_arvalid[1]), .m1_arready(m_arready[1]), .m1_ar_info(m_ar_info[1]),
    .m1_rvalid(m_rvalid[1]), .m1_rready(m_rready[1]), .m1_r_info(m_r_info[1]),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_ar_info(s_ar_info),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_r_info(s_r_info),
    .grant(grant), .timeout_pulse(timeout_pulse)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [AIW-1:0] mk_ar(input logic [AW-1:0] a, input logic [3:0] id, input logic [7:0] len);
    return {a, id, len, 3'd3, 2'b01};
  endfunction

  function automatic logic [RIW-1:0] mk_r(input logic [DW-1:0] d, input logic [1:0] resp, input logic last, input logic [3:0] id);
    return {d, resp, last, id};
  endfunction

  function automatic logic [DW-1:0] bdata(input logic [AW-1:0] a, input int k);
    return {a, 24'h5A5A5A, 8'(k)};
  endfunction

  // ---------------- transaction-level environment ----------------
  bit             eng_issue;
  int             rr_pct;
  logic [AW-1:0]  e_addr [2];
  logic [3:0]     e_id [2];
  logic [7:0]     e_len [2];
  int             e_k [2];
  bit             e_pend [2];
  bit             e_busy [2];
  int             e_done [2];
  int             e_issued [2];
  logic [RIW-1:0] sq [$];
  int             gap;
  logic [1:0]     prev_req, prev_grant;
  logic [1:0]     order [$];
  int             last_model;

  function automatic logic [1:0] tie_winner();
`ifdef ARB_ROUND_ROBIN_EN
    return (last_model == 1) ? 2'b01 : 2'b10;
`else
    return 2'b10;
`endif
  endfunction

  task automatic do_reset();
    reset = 1'b1; m_arvalid = '0; m_rready = '0; s_arready = 1'b0; s_rvalid = 1'b0; s_r_info = '0;
    m_ar_info[0] = '0; m_ar_info[1] = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    sq.delete(); order.delete(); gap = 0; prev_req = '0; prev_grant = '0; last_model = 1;
    for (int m = 0; m < 2; m++) begin
      e_pend[m] = 0; e_busy[m] = 0; e_k[m] = 0; e_done[m] = 0; e_issued[m] = 0;
    end
  endtask

  task automatic eng_cycle();
    int own;
    logic [7:0] len;
    @(negedge clock);
    if (grant != 2'b00 && prev_grant == 2'b00) begin
      chk("arb_winner", grant, (prev_req == 2'b11) ? tie_winner() : prev_req);
      last_model = (grant == 2'b10) ? 1 : 0;
      order.push_back(grant);
    end
    if (s_arvalid && s_arready) begin
      own = m_arready[1] ? 1 : 0;
      chk("ar_forward", s_ar_info, mk_ar(e_addr[own], e_id[own], e_len[own]));
      if ($urandom_range(0, 3) == 0) sq.push_back(mk_r(64'hDEAD_BEEF, 2'b00, 1'b1, s_ar_info[16:13] ^ 4'h8));
      len = s_ar_info[12:5];
      for (int k = 0; k <= int'(len); k++)
        sq.push_back(mk_r(bdata(s_ar_info[AIW-1:17], k), 2'b00, k == int'(len), s_ar_info[16:13]));
    end
    for (int m = 0; m < 2; m++) begin
      if (!e_busy[m]) chk("rvalid_idle_master", m_rvalid[m], 1'b0);
      if (m_arvalid[m] && m_arready[m]) begin
        e_pend[m] = 0; e_busy[m] = 1; e_k[m] = 0;
      end else if (e_busy[m] && m_rvalid[m] && m_rready[m]) begin
        chk("beat", m_r_info[m], mk_r(bdata(e_addr[m], e_k[m]), 2'b00, e_k[m] == int'(e_len[m]), e_id[m]));
        e_k[m]++;
        if (e_k[m] > int'(e_len[m])) begin e_busy[m] = 0; e_done[m]++; end
      end
    end
    if (s_rvalid && s_rready && sq.size() > 0) begin
      void'(sq.pop_front());
      gap = $urandom_range(0, 2);
    end
    prev_req = m_arvalid; prev_grant = grant;
    @(posedge clock);
    #1;
    for (int m = 0; m < 2; m++) begin
      if (eng_issue && !e_pend[m] && !e_busy[m] && $urandom_range(0, 2) == 0) begin
        e_addr[m] = $urandom; e_id[m] = 4'($urandom); e_len[m] = 8'($urandom_range(0, 3));
        e_pend[m] = 1; e_issued[m]++;
      end
      m_arvalid[m] = e_pend[m];
      m_ar_info[m] = mk_ar(e_addr[m], e_id[m], e_len[m]);
      m_rready[m]  = ($urandom_range(0, 99) < rr_pct);
    end
    s_arready = 1'($urandom_range(0, 1));
    if (sq.size() > 0 && gap == 0) begin
      s_rvalid = 1'b1; s_r_info = sq[0];
    end else begin
      s_rvalid = 1'b0; s_r_info = '0;
      if (gap > 0) gap--;
    end
  endtask

  // ---------------- cycle-exact single read ----------------
  task automatic simple_read(input int m, input logic [AW-1:0] addr, input logic [3:0] id, input logic [DW-1:0] data);
    logic [AIW-1:0] ar;
    logic [RIW-1:0] r;
    logic [1:0] g;
    ar = mk_ar(addr, id, 8'd0); r = mk_r(data, 2'b00, 1'b1, id); g = (m == 1) ? 2'b10 : 2'b01;
    m_arvalid[m] = 1'b1; m_ar_info[m] = ar; m_rready[m] = 1'b1; s_arready = 1'b1;
    @(negedge clock);
    chk("rd_idle_grant", grant, 2'b00);
    chk("rd_idle_sarvalid", s_arvalid, 1'b0);
    @(posedge clock); #1;
    @(negedge clock);
    chk("rd_sarvalid", s_arvalid, 1'b1);
    chk("rd_sarinfo", s_ar_info, ar);
    chk("rd_grant", grant, g);
    chk("rd_arready", m_arready, g);
    @(posedge clock); #1;
    m_arvalid[m] = 1'b0; s_arready = 1'b0;
    @(negedge clock);
    chk("rd_wait_rvalid", m_rvalid, 2'b00);
    @(posedge clock); #1;
    s_rvalid = 1'b1; s_r_info = r;
    @(negedge clock);
    chk("rd_rvalid", m_rvalid, g);
    chk("rd_rinfo", m_r_info[m], r);
    chk("rd_other_rinfo", m_r_info[1-m], '0);
    chk("rd_srready", s_rready, 1'b1);
    @(posedge clock); #1;
    s_rvalid = 1'b0; s_r_info = '0; m_rready[m] = 1'b0;
    @(negedge clock);
    chk("rd_done_grant", grant, 2'b00);
    @(posedge clock); #1;
  endtask

  typedef struct {
    logic [1:0] req;
    logic [1:0] first;
    logic [1:0] second;
  } vec_t;
  vec_t tbl [6];

  initial begin
    #2_000_000;
    $display("FAIL sim_watchdog: simulation still running, required finish before 2000000");
    $fatal(1);
  end

  initial begin
    logic [RIW-1:0] exp_b;
    int lat;
    eng_issue = 0; rr_pct = 100;
    tbl[0] = '{2'b01, 2'b01, 2'b00};
    tbl[1] = '{2'b10, 2'b10, 2'b00};
`ifdef ARB_ROUND_ROBIN_EN
    tbl[2] = '{2'b11, 2'b01, 2'b10};
`else
    tbl[2] = '{2'b11, 2'b10, 2'b01};
`endif
    tbl[3] = '{2'b01, 2'b01, 2'b00};
    tbl[4] = '{2'b11, 2'b10, 2'b01};
    tbl[5] = '{2'b11, 2'b10, 2'b01};

    do_reset();
    @(negedge clock);
    chk("reset_outputs", {m_arready, m_rvalid, s_arvalid, s_rready, grant, timeout_pulse}, '0);
    chk("reset_rinfo", {m_r_info[0], m_r_info[1]}, '0);
    @(posedge clock); #1;

    simple_read(0, 32'h8000_0000, 4'd3, 64'h1122_3344_5566_7788);
    simple_read(1, 32'h0000_4400, 4'd1, 64'h0BAD_F00D_0000_0001);

    // burst of 4 to m1 with rready toggled
    m_arvalid[1] = 1'b1; m_ar_info[1] = mk_ar(32'h1000, 4'd4, 8'd3); s_arready = 1'b1; m_rready[1] = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    m_arvalid[1] = 1'b0; s_arready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      exp_b = mk_r(bdata(32'h1000, k), 2'b00, k == 3, 4'd4);
      s_rvalid = 1'b1; s_r_info = exp_b; m_rready[1] = 1'b0;
      @(negedge clock);
      chk("burst_hold_rvalid", m_rvalid, 2'b10);
      chk("burst_hold_srready", s_rready, 1'b0);
      @(posedge clock); #1;
      m_rready[1] = 1'b1;
      @(negedge clock);
      chk("burst_beat", m_r_info[1], exp_b);
      chk("burst_grant", grant, 2'b10);
      @(posedge clock); #1;
    end
    s_rvalid = 1'b0; s_r_info = '0; m_rready[1] = 1'b0;
    @(negedge clock);
    chk("burst_end_grant", grant, 2'b00);
    @(posedge clock); #1;

    // stray rid 9 while waiting on arid 5
    m_arvalid[0] = 1'b1; m_ar_info[0] = mk_ar(32'h4000, 4'd5, 8'd0); s_arready = 1'b1; m_rready[0] = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    m_arvalid[0] = 1'b0; s_arready = 1'b0;
    s_rvalid = 1'b1; s_r_info = mk_r(64'h0BAD, 2'b00, 1'b1, 4'd9);
    @(negedge clock);
    chk("stray_srready", s_rready, 1'b1);
    chk("stray_hidden", m_rvalid, 2'b00);
    chk("stray_rinfo", m_r_info[0], '0);
    @(posedge clock); #1;
    exp_b = mk_r(64'h5555_6666_7777_8888, 2'b00, 1'b1, 4'd5);
    s_r_info = exp_b;
    @(negedge clock);
    chk("stray_grant_kept", grant, 2'b01);
    chk("stray_good_rvalid", m_rvalid, 2'b01);
    chk("stray_good_rinfo", m_r_info[0], exp_b);
    @(posedge clock); #1;
    s_rvalid = 1'b0; s_r_info = '0; m_rready[0] = 1'b0;
    @(negedge clock);
    chk("stray_end_grant", grant, 2'b00);
    @(posedge clock); #1;

    // watchdog with a silent slave
    m_arvalid[0] = 1'b1; m_ar_info[0] = mk_ar(32'h5000, 4'd6, 8'd0); s_arready = 1'b1; m_rready[0] = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    m_arvalid[0] = 1'b0; s_arready = 1'b0;
    lat = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (m_rvalid[0]) begin lat = c; break; end
      @(posedge clock); #1;
    end
    chk("timeout_latency", lat, 8);
    chk("timeout_rinfo", m_r_info[0], mk_r('0, 2'b10, 1'b1, 4'd6));
    chk("timeout_no_early_pulse", timeout_pulse, 1'b0);
    @(posedge clock); #1;
    @(negedge clock);
    chk("timeout_beat_held", m_rvalid, 2'b01);
    @(posedge clock); #1;
    m_rready[0] = 1'b1;
    @(negedge clock);
    chk("timeout_beat_taken", m_rvalid, 2'b01);
    @(posedge clock); #1;
    @(negedge clock);
    chk("timeout_pulse", timeout_pulse, 1'b1);
    chk("drain_grant", grant, 2'b00);
    chk("drain_srready", s_rready, 1'b1);
    @(posedge clock); #1;
    s_rvalid = 1'b1; s_r_info = mk_r(64'hFEED, 2'b00, 1'b1, 4'd6);
    @(negedge clock);
    chk("drain_hidden", m_rvalid, 2'b00);
    chk("pulse_single", timeout_pulse, 1'b0);
    @(posedge clock); #1;
    s_rvalid = 1'b0; s_r_info = '0; m_rready[0] = 1'b0;
    simple_read(0, 32'h5100, 4'd2, 64'h0123_4567_89AB_CDEF);

    // reset while in R_WAIT
    m_arvalid[0] = 1'b1; m_ar_info[0] = mk_ar(32'h2000, 4'd7, 8'd0); s_arready = 1'b1; m_rready[0] = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    m_arvalid[0] = 1'b0; s_arready = 1'b0;
    @(negedge clock);
    chk("rst_pre_grant", grant, 2'b01);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0; s_rvalid = 1'b1; s_r_info = mk_r(64'h77, 2'b00, 1'b1, 4'd7);
    @(negedge clock);
    chk("rst_outputs", {m_arready, m_rvalid, s_arvalid, s_rready, grant, timeout_pulse}, '0);
    chk("rst_rinfo", m_r_info[0], '0);
    @(posedge clock); #1;
    s_rvalid = 1'b0; s_r_info = '0; m_rready = '0;
    simple_read(0, 32'h3000, 4'd2, 64'hCAFE_0000_BEEF_0001);

    // arbitration table
    do_reset();
    for (int i = 0; i < 6; i++) begin
      order.delete();
      for (int m = 0; m < 2; m++) begin
        if (tbl[i].req[m]) begin
          e_addr[m] = 32'h0001_0000 * (i + 1) + 32'(m); e_id[m] = 4'(i + 2 * m); e_len[m] = 8'(m);
          e_pend[m] = 1;
        end
      end
      for (int c = 0; c < 100 && (e_pend[0] || e_pend[1] || e_busy[0] || e_busy[1]); c++) eng_cycle();
      chk("tbl_complete", {e_pend[0], e_pend[1], e_busy[0], e_busy[1]}, '0);
      chk("tbl_first", (order.size() > 0) ? order[0] : 2'b00, tbl[i].first);
      chk("tbl_second", (order.size() > 1) ? order[1] : 2'b00, tbl[i].second);
    end

    // randomized traffic
    do_reset();
    eng_issue = 1; rr_pct = 70;
    for (int c = 0; c < 1500; c++) eng_cycle();
    eng_issue = 0;
    for (int c = 0; c < 300 && (e_pend[0] || e_pend[1] || e_busy[0] || e_busy[1]); c++) eng_cycle();
    chk("rand_drained", {e_pend[0], e_pend[1], e_busy[0], e_busy[1]}, '0);
    chk("rand_m0_served", e_done[0], e_issued[0]);
    chk("rand_m1_served", e_done[1], e_issued[1]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
